// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified MIPS instruction/data memory.
package mips_mem_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_INIT   = 32'h8002_0000;
    localparam word_t SP_INIT   = 32'h8012_0000;
    localparam word_t NOP_WORD  = 32'h0000_0000;
    localparam word_t MEM_BASE  = 32'h8000_0000;
    localparam word_t MEM_DEPTH = 32'h0008_0000;

    function automatic logic is_aligned(input word_t addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mips_mem_decode.sv
// Address decode: window hit, word alignment and word index for one byte address.
module mips_mem_decode
    import mips_mem_pkg::*;
#(
    parameter word_t       BASE_ADDR   = MEM_BASE,
    parameter word_t       DEPTH_WORDS = MEM_DEPTH,
    parameter int unsigned IDX_W       = 19
) (
    input  word_t             addr,
    output logic              hit_c,
    output logic              aligned_c,
    output logic [IDX_W-1:0]  index_c
);

    localparam logic [33:0] SPAN_BYTES = {DEPTH_WORDS, 2'b00};

    word_t offset;

    // Lower-bound check guards against the subtract wrapping into the window.
    assign offset    = addr - BASE_ADDR;
    assign hit_c     = (addr >= BASE_ADDR) && ({2'b00, offset} < SPAN_BYTES);
    assign aligned_c = is_aligned(addr);
    assign index_c   = IDX_W'(offset >> 2);

endmodule

// File: rtl/mips_memory.sv
// Unified instruction/data word memory with registered reads, preload port,
// sticky error flags and data-port access counters.
module mips_memory
    import mips_mem_pkg::*;
#(
    parameter word_t BASE_ADDR   = MEM_BASE,
    parameter word_t DEPTH_WORDS = MEM_DEPTH,
    parameter word_t RESET_DATA  = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_in,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_rd_wr,
    output logic [31:0] data_in,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err_range,
    output logic        err_align,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    word_t mem [0:DEPTH_WORDS-1];

    logic             f_hit, f_aligned;
    logic             d_hit, d_aligned;
    logic             p_hit, p_aligned;
    logic [IDX_W-1:0] f_idx, d_idx, p_idx;

    logic             cpu_wr_c;
    logic             wr_en_c;
    logic [IDX_W-1:0] wr_idx_c;
    word_t            wr_data_c;
    word_t            fetch_word_c;
    word_t            load_word_c;
    logic             wr_prev;

    mips_mem_decode #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_dec_fetch (
        .addr(instr_addr), .hit_c(f_hit), .aligned_c(f_aligned), .index_c(f_idx)
    );

    mips_mem_decode #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_dec_data (
        .addr(data_addr), .hit_c(d_hit), .aligned_c(d_aligned), .index_c(d_idx)
    );

    mips_mem_decode #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_dec_load (
        .addr(load_addr), .hit_c(p_hit), .aligned_c(p_aligned), .index_c(p_idx)
    );

    assign cpu_wr_c = !data_rd_wr && d_hit && d_aligned;

    // Single write port: preload wins over a CPU store; nothing commits during reset.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_idx_c  = p_idx;
        wr_data_c = load_data;
        if (!reset) begin
            if (load_en) begin
                wr_en_c = p_hit;
            end else if (cpu_wr_c) begin
                wr_en_c   = 1'b1;
                wr_idx_c  = d_idx;
                wr_data_c = data_out;
            end
        end
    end

    // Write-first forwarding for both read ports.
    assign fetch_word_c = (wr_en_c && (wr_idx_c == f_idx)) ? wr_data_c : mem[f_idx];
    assign load_word_c  = (wr_en_c && (wr_idx_c == d_idx)) ? wr_data_c : mem[d_idx];

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= wr_data_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_in  <= RESET_DATA;
            data_in   <= RESET_DATA;
            err_range <= 1'b0;
            err_align <= 1'b0;
            rd_count  <= 32'd0;
            wr_count  <= 32'd0;
            wr_prev   <= 1'b0;
        end else begin
            instr_in <= f_hit ? fetch_word_c : RESET_DATA;
            if (data_rd_wr) begin
                data_in  <= d_hit ? load_word_c : RESET_DATA;
                rd_count <= rd_count + 32'd1;
            end
            // Count a store run once, on its first committed cycle.
            if (!load_en && cpu_wr_c && !wr_prev) begin
                wr_count <= wr_count + 32'd1;
            end
            wr_prev   <= !data_rd_wr;
            err_range <= err_range | !f_hit | !d_hit;
            err_align <= err_align | !f_aligned | !d_aligned;
        end
    end

    // The preload port has no alignment check; its decode bit is intentionally unused.
    logic unused_ok;
    assign unused_ok = p_aligned;

endmodule

// File: tb/tb_mips_memory.sv
// Directed self-checking bench for mips_memory.
module tb_mips_memory;
    import mips_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] instr_addr, instr_in;
    logic [31:0] data_addr, data_out, data_in;
    logic        data_rd_wr;
    logic        load_en;
    logic [31:0] load_addr, load_data;
    logic        err_range, err_align;
    logic [31:0] rd_count, wr_count;

    int tests  = 0;
    int failed = 0;

    mips_memory dut (
        .clk(clk), .reset(reset),
        .instr_addr(instr_addr), .instr_in(instr_in),
        .data_addr(data_addr), .data_out(data_out), .data_rd_wr(data_rd_wr), .data_in(data_in),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .err_range(err_range), .err_align(err_align),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        data_rd_wr = 1'b1; data_addr = 32'h8002_0000; data_out = '0;
        instr_addr = PC_INIT;
        cyc(); cyc();
        check("rst_instr_in",  instr_in, 32'h0);
        check("rst_data_in",   data_in, 32'h0);
        check("rst_err_range", 32'(err_range), 32'h0);
        check("rst_err_align", 32'(err_align), 32'h0);
        check("rst_rd_count",  rd_count, 32'h0);
        check("rst_wr_count",  wr_count, 32'h0);

        // Program image preload, including one out-of-window preload
        reset = 1'b0; load_en = 1'b1;
        load_addr = PC_INIT;        load_data = 32'h27BD_FFF8; cyc();
        load_addr = SP_INIT;        load_data = 32'hCAFE_0001; cyc();
        load_addr = 32'h8002_0008;  load_data = 32'h0BAD_F00D; cyc();
        load_addr = 32'h8002_001C;  load_data = 32'h6666_6666; cyc();
        load_addr = 32'h0000_0000;  load_data = 32'hFFFF_FFFF; cyc();
        load_en = 1'b0; cyc();
        check("t1_fetch",       instr_in, 32'h27BD_FFF8);
        check("t1_data_read",   data_in, 32'h27BD_FFF8);
        check("t1_no_err_miss", 32'(err_range), 32'h0);

        // Store run of three cycles counts once
        data_rd_wr = 1'b0; data_addr = 32'h8011_FFF8; data_out = 32'hDEAD_BEEF;
        cyc(); cyc(); cyc();
        check("t2_wr_count", wr_count, 32'd1);
        check("t2_hold",     data_in, 32'h27BD_FFF8);
        data_rd_wr = 1'b1; cyc();
        check("t2_read",      data_in, 32'hDEAD_BEEF);
        check("t2_wr_count2", wr_count, 32'd1);

        // Write-first forwarding to the fetch port
        data_rd_wr = 1'b0; data_addr = 32'h8002_0004; data_out = 32'h1234_5678;
        instr_addr = 32'h8002_0004; cyc();
        check("t3_fwd_fetch", instr_in, 32'h1234_5678);
        check("t3_wr_count",  wr_count, 32'd2);
        data_rd_wr = 1'b1; cyc();
        check("t3_read", data_in, 32'h1234_5678);

        // Window boundaries: last and first word are hits
        data_rd_wr = 1'b0; data_addr = 32'h801F_FFFC; data_out = 32'hA5A5_5A5A; cyc();
        data_rd_wr = 1'b1; cyc();
        check("edge_last_word", data_in, 32'hA5A5_5A5A);
        data_rd_wr = 1'b0; data_addr = 32'h8000_0000; data_out = 32'h0102_0304; cyc();
        data_rd_wr = 1'b1; cyc();
        check("edge_first_word", data_in, 32'h0102_0304);
        check("edge_wr_count",   wr_count, 32'd4);
        check("edge_no_range",   32'(err_range), 32'h0);
        check("edge_no_align",   32'(err_align), 32'h0);

        // Preload beats a same-cycle CPU store, which is dropped and not counted
        load_en = 1'b1; load_addr = 32'h8002_0018; load_data = 32'h7777_7777;
        data_rd_wr = 1'b0; data_addr = 32'h8002_001C; data_out = 32'h8888_8888; cyc();
        load_en = 1'b0; data_rd_wr = 1'b1; cyc();
        check("prio_cpu_dropped", data_in, 32'h6666_6666);
        check("prio_wr_count",    wr_count, 32'd4);
        data_addr = 32'h8002_0018; cyc();
        check("prio_preload", data_in, 32'h7777_7777);

        // Out-of-window reads
        data_addr = 32'h7FFF_FFFC; cyc();
        check("t4_below_data",  data_in, 32'h0);
        check("t4_err_range",   32'(err_range), 32'h1);
        check("t4_err_align",   32'(err_align), 32'h0);
        data_addr = 32'h8002_0004; cyc();
        check("t4_reload", data_in, 32'h1234_5678);
        data_addr = 32'h8020_0000; cyc();
        check("t4_above_data", data_in, 32'h0);
        data_addr = 32'h8011_FFF8; cyc();
        check("t4_mem_intact", data_in, 32'hDEAD_BEEF);

        // Misaligned store suppressed; misaligned read uses word index
        data_rd_wr = 1'b0; data_addr = 32'h8012_0002; data_out = 32'hFFFF_FFFF; cyc();
        check("t5_err_align", 32'(err_align), 32'h1);
        check("t5_hold",      data_in, 32'hDEAD_BEEF);
        data_rd_wr = 1'b1; data_addr = 32'h8012_0000; cyc();
        check("t5_no_write", data_in, 32'hCAFE_0001);
        check("t5_wr_count", wr_count, 32'd4);
        data_addr = 32'h8012_0003; cyc();
        check("t5_misal_read", data_in, 32'hCAFE_0001);

        // Reset in the middle of a store run with a pending preload
        data_rd_wr = 1'b0; data_addr = 32'h8002_0010; data_out = 32'h2222_2222; cyc();
        reset = 1'b1; load_en = 1'b1; load_addr = 32'h8002_0008; load_data = 32'hFFFF_FFFF;
        data_out = 32'h3333_3333; cyc();
        check("t6_instr_in",  instr_in, 32'h0);
        check("t6_data_in",   data_in, 32'h0);
        check("t6_err_range", 32'(err_range), 32'h0);
        check("t6_err_align", 32'(err_align), 32'h0);
        check("t6_rd_count",  rd_count, 32'h0);
        check("t6_wr_count",  wr_count, 32'h0);
        reset = 1'b0; load_en = 1'b0; data_rd_wr = 1'b1;
        data_addr = 32'h8002_0008; instr_addr = PC_INIT; cyc();
        check("t6_preload_kept", data_in, 32'h0BAD_F00D);
        check("t6_fetch_kept",   instr_in, 32'h27BD_FFF8);
        data_addr = 32'h8002_0010; cyc();
        check("t6_store_dropped", data_in, 32'h2222_2222);
        data_addr = 32'h8012_0000; cyc();
        check("t6_sp_word",    data_in, 32'hCAFE_0001);
        check("t6_rd_count3",  rd_count, 32'd3);
        check("t6_range_clr",  32'(err_range), 32'h0);
        check("t6_align_clr",  32'(err_align), 32'h0);
        check("t6_wr_count0",  wr_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
